// File: rtl/arbitro_libro_mayor.sv
// Round-robin arbiter and sequencer that shares one ledger update engine
// among N_TERM cashier terminals. It grants one terminal, strobes the ledger and waits for completion.
//
// Ports:
//   clock                 rising-edge system clock
//   reset                 asynchronous active-low reset
//   req[N_TERM]           per-terminal request level, held until its ack
//   tipo_trans[N_TERM]    per-terminal type: 0 = deposit, 1 = withdrawal
//   monto[N_TERM*MONTO_W] per-terminal amount, terminal i at [i*MONTO_W +: MONTO_W]
//   ledger_ack            ledger finished the current command (1-cycle pulse)
//   ledger_insuf          valid with ledger_ack: withdrawal refused
//   grant[N_TERM]         one-hot ledger owner, all 0 when free
//   ledger_stb            1-cycle command strobe to the ledger
//   ledger_tipo           latched type of the granted request
//   ledger_monto          latched amount of the granted request
//   ack[N_TERM]           1-cycle completion pulse to the granted terminal
//   fondos_insuficientes  valid with ack: insufficient funds
//   error_timeout         valid with ack: ledger never answered
//   ocupado               high whenever the sequencer is not idle
module arbitro_libro_mayor #(
    parameter int N_TERM  = 4,
    parameter int MONTO_W = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_TERM-1:0]         req,
    input  logic [N_TERM-1:0]         tipo_trans,
    input  logic [N_TERM*MONTO_W-1:0] monto,
    input  logic                      ledger_ack,
    input  logic                      ledger_insuf,
    output logic [N_TERM-1:0]         grant,
    output logic                      ledger_stb,
    output logic                      ledger_tipo,
    output logic [MONTO_W-1:0]        ledger_monto,
    output logic [N_TERM-1:0]         ack,
    output logic                      fondos_insuficientes,
    output logic                      error_timeout,
    output logic                      ocupado
);

    localparam int PW = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RELEASE
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_win;
    logic [TW-1:0]       r_timer;
    logic                r_abort;
    logic [N_TERM-1:0]   r_grant;
    logic                r_stb;
    logic                r_tipo;
    logic [MONTO_W-1:0]  r_monto;
    logic [N_TERM-1:0]   r_ack;
    logic                r_insuf;
    logic                r_tout;
    logic                r_ocupado;

    logic [PW-1:0]       w_win;
    logic [N_TERM-1:0]   w_onehot;
    logic                w_tipo;
    logic [MONTO_W-1:0]  w_monto;
    logic                w_req_own;
    logic                w_done;
    logic [PW-1:0]       w_ptr_next;

    // First set request scanning upward from ptr, wrapping at N_TERM.
    // The scan runs from the farthest candidate back to ptr so the
    // closest one is written last and wins.
    function automatic logic [PW-1:0] pick(
        input logic [N_TERM-1:0] r,
        input logic [PW-1:0]     p
    );
        logic [PW-1:0] w;
        int            idx;
        w = '0;
        for (int k = N_TERM - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= N_TERM) begin
                idx = idx - N_TERM;
            end
            if (r[idx[PW-1:0]]) begin
                w = PW'(idx);
            end
        end
        return w;
    endfunction

    always_comb begin
        w_win    = pick(req, r_ptr);
        w_onehot = N_TERM'(1) << w_win;
    end

    // Operand mux for the winning terminal.
    always_comb begin
        w_tipo  = 1'b0;
        w_monto = '0;
        for (int i = 0; i < N_TERM; i++) begin
            if (PW'(i) == w_win) begin
                w_tipo  = tipo_trans[i];
                w_monto = monto[i*MONTO_W +: MONTO_W];
            end
        end
    end

    // Owner still holding its request line.
    assign w_req_own = |(req & r_grant);

    // Ledger answer wins over a coinciding timeout.
    assign w_done = ledger_ack || (r_timer == TW'(TIMEOUT - 1));

    assign w_ptr_next = (r_win == PW'(N_TERM - 1)) ? '0 : r_win + PW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_timer   <= '0;
            r_abort   <= 1'b0;
            r_grant   <= '0;
            r_stb     <= 1'b0;
            r_tipo    <= 1'b0;
            r_monto   <= '0;
            r_ack     <= '0;
            r_insuf   <= 1'b0;
            r_tout    <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            r_ack   <= '0;
            r_insuf <= 1'b0;
            r_tout  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_grant   <= w_onehot;
                        r_win     <= w_win;
                        r_stb     <= 1'b1;
                        r_tipo    <= w_tipo;
                        r_monto   <= w_monto;
                        r_timer   <= '0;
                        r_abort   <= 1'b0;
                        r_ocupado <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_stb   <= 1'b0;
                    r_state <= WAIT;
                    if (!w_req_own) begin
                        r_abort <= 1'b1;
                    end
                end
                WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    if (w_done) begin
                        // A requester that walked away gets no ack,
                        // but the status flags still report the outcome.
                        r_ack   <= (r_abort || !w_req_own) ? '0 : r_grant;
                        r_insuf <= ledger_ack & ledger_insuf;
                        r_tout  <= !ledger_ack;
                        r_state <= RELEASE;
                    end else if (!w_req_own) begin
                        r_abort <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!w_req_own) begin
                        r_grant   <= '0;
                        r_ptr     <= w_ptr_next;
                        r_ocupado <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant                = r_grant;
    assign ledger_stb           = r_stb;
    assign ledger_tipo          = r_tipo;
    assign ledger_monto         = r_monto;
    assign ack                  = r_ack;
    assign fondos_insuficientes = r_insuf;
    assign error_timeout        = r_tout;
    assign ocupado              = r_ocupado;

endmodule

// File: tb/tb_arbitro_libro_mayor.sv
// Directed bench for arbitro_libro_mayor (N_TERM=4, MONTO_W=32, TIMEOUT=8).
// Checks arbitration order, ledger sequencing, timeout, abort and reset.
module tb_arbitro_libro_mayor;

    localparam int N  = 4;
    localparam int MW = 32;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    tipo_trans;
    logic [N*MW-1:0] monto;
    logic            ledger_ack;
    logic            ledger_insuf;
    logic [N-1:0]    grant;
    logic            ledger_stb;
    logic            ledger_tipo;
    logic [MW-1:0]   ledger_monto;
    logic [N-1:0]    ack;
    logic            fondos_insuficientes;
    logic            error_timeout;
    logic            ocupado;

    int n_vec;
    int n_err;

    arbitro_libro_mayor #(
        .N_TERM  (N),
        .MONTO_W (MW),
        .TIMEOUT (8)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .req                  (req),
        .tipo_trans           (tipo_trans),
        .monto                (monto),
        .ledger_ack           (ledger_ack),
        .ledger_insuf         (ledger_insuf),
        .grant                (grant),
        .ledger_stb           (ledger_stb),
        .ledger_tipo          (ledger_tipo),
        .ledger_monto         (ledger_monto),
        .ack                  (ack),
        .fondos_insuficientes (fondos_insuficientes),
        .error_timeout        (error_timeout),
        .ocupado              (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b0;
        req          = '0;
        tipo_trans   = '0;
        monto        = '0;
        ledger_ack   = 1'b0;
        ledger_insuf = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_stb", 64'(ledger_stb), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_ocupado", 64'(ocupado), 64'h0);
        chk("rst_monto", 64'(ledger_monto), 64'h0);
        reset = 1'b1;

        // 1: single deposit, ledger_ack 3 cycles after stb
        req              = 4'b0001;
        monto[0*MW +: MW] = 32'd500;
        tick();
        chk("t1_grant", 64'(grant), 64'h1);
        chk("t1_stb", 64'(ledger_stb), 64'h1);
        chk("t1_monto", 64'(ledger_monto), 64'd500);
        chk("t1_tipo", 64'(ledger_tipo), 64'h0);
        chk("t1_ocupado", 64'(ocupado), 64'h1);
        monto[0*MW +: MW] = 32'd777;
        tipo_trans        = 4'b0001;
        tick();
        chk("t1_stb_drop", 64'(ledger_stb), 64'h0);
        chk("t1_monto_latched", 64'(ledger_monto), 64'd500);
        chk("t1_tipo_latched", 64'(ledger_tipo), 64'h0);
        tick();
        tick();
        ledger_ack = 1'b1;
        tick();
        ledger_ack = 1'b0;
        chk("t1_ack", 64'(ack), 64'h1);
        chk("t1_insuf", 64'(fondos_insuficientes), 64'h0);
        chk("t1_tout", 64'(error_timeout), 64'h0);
        tick();
        chk("t1_ack_pulse", 64'(ack), 64'h0);
        chk("t1_grant_held", 64'(grant), 64'h1);
        req = 4'b0000;
        tick();
        chk("t1_grant_clr", 64'(grant), 64'h0);
        chk("t1_idle", 64'(ocupado), 64'h0);
        tipo_trans = '0;

        // 2: reset to ptr=0, then req=0101
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req               = 4'b0101;
        monto[0*MW +: MW] = 32'd100;
        monto[2*MW +: MW] = 32'd300;
        tipo_trans        = 4'b0100;
        tick();
        chk("t2_grant0", 64'(grant), 64'h1);
        chk("t2_monto0", 64'(ledger_monto), 64'd100);
        tick();
        ledger_ack = 1'b1;
        tick();
        ledger_ack = 1'b0;
        chk("t2_ack0", 64'(ack), 64'h1);
        req = 4'b0100;
        tick();
        chk("t2_rel0", 64'(grant), 64'h0);
        req = 4'b0101;
        tick();
        chk("t2_grant2", 64'(grant), 64'h4);
        chk("t2_monto2", 64'(ledger_monto), 64'd300);
        chk("t2_tipo2", 64'(ledger_tipo), 64'h1);
        tick();
        ledger_ack = 1'b1;
        tick();
        ledger_ack = 1'b0;
        chk("t2_ack2", 64'(ack), 64'h4);
        req = 4'b0001;
        tick();
        chk("t2_rel2", 64'(grant), 64'h0);
        tick();
        chk("t2_grant0_again", 64'(grant), 64'h1);
        tick();
        ledger_ack = 1'b1;
        tick();
        ledger_ack = 1'b0;
        chk("t2_ack0_again", 64'(ack), 64'h1);
        req = 4'b0000;
        tick();
        chk("t2_rel0_again", 64'(grant), 64'h0);
        tipo_trans = '0;

        // 3: withdrawal 900 refused (ptr=1)
        req               = 4'b0010;
        tipo_trans        = 4'b0010;
        monto[1*MW +: MW] = 32'd900;
        tick();
        chk("t3_grant", 64'(grant), 64'h2);
        chk("t3_tipo", 64'(ledger_tipo), 64'h1);
        chk("t3_monto", 64'(ledger_monto), 64'd900);
        tick();
        ledger_ack   = 1'b1;
        ledger_insuf = 1'b1;
        tick();
        ledger_ack   = 1'b0;
        ledger_insuf = 1'b0;
        chk("t3_ack", 64'(ack), 64'h2);
        chk("t3_insuf", 64'(fondos_insuficientes), 64'h1);
        chk("t3_tout", 64'(error_timeout), 64'h0);
        req = 4'b0000;
        tick();
        chk("t3_insuf_pulse", 64'(fondos_insuficientes), 64'h0);
        chk("t3_rel", 64'(grant), 64'h0);
        tipo_trans = '0;

        // 4a: ledger silent, timeout 8 cycles after WAIT entry (ptr=2)
        req = 4'b1000;
        tick();
        chk("t4_grant", 64'(grant), 64'h8);
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("t4_no_ack_yet", 64'(ack), 64'h0);
        tick();
        chk("t4_ack", 64'(ack), 64'h8);
        chk("t4_tout", 64'(error_timeout), 64'h1);
        chk("t4_insuf", 64'(fondos_insuficientes), 64'h0);
        req = 4'b0000;
        tick();
        chk("t4_tout_pulse", 64'(error_timeout), 64'h0);
        chk("t4_rel", 64'(grant), 64'h0);

        // 4b: ledger_ack on the timeout cycle wins (ptr=0)
        req = 4'b0001;
        tick();
        chk("t4b_grant", 64'(grant), 64'h1);
        tick();
        for (int i = 0; i < 7; i++) tick();
        ledger_ack = 1'b1;
        tick();
        ledger_ack = 1'b0;
        chk("t4b_ack", 64'(ack), 64'h1);
        chk("t4b_tout", 64'(error_timeout), 64'h0);
        req = 4'b0000;
        tick();
        chk("t4b_rel", 64'(grant), 64'h0);

        // 5: req[1] drops mid-WAIT (ptr=1), terminal 2 pending
        req = 4'b0110;
        tick();
        chk("t5_grant1", 64'(grant), 64'h2);
        tick();
        req = 4'b0100;
        tick();
        ledger_ack   = 1'b1;
        ledger_insuf = 1'b1;
        tick();
        ledger_ack   = 1'b0;
        ledger_insuf = 1'b0;
        chk("t5_ack_suppr", 64'(ack), 64'h0);
        chk("t5_insuf", 64'(fondos_insuficientes), 64'h1);
        chk("t5_grant_held", 64'(grant), 64'h2);
        tick();
        chk("t5_rel", 64'(grant), 64'h0);
        tick();
        chk("t5_grant2", 64'(grant), 64'h4);
        tick();
        ledger_ack = 1'b1;
        tick();
        ledger_ack = 1'b0;
        chk("t5_ack2", 64'(ack), 64'h4);
        req = 4'b0000;
        tick();
        chk("t5_rel2", 64'(grant), 64'h0);

        // 6: async reset mid-WAIT (ptr=3)
        req = 4'b0010;
        tick();
        chk("t6_grant1", 64'(grant), 64'h2);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_async_grant", 64'(grant), 64'h0);
        chk("t6_async_stb", 64'(ledger_stb), 64'h0);
        chk("t6_async_ack", 64'(ack), 64'h0);
        chk("t6_async_ocupado", 64'(ocupado), 64'h0);
        tick();
        reset = 1'b1;
        req   = 4'b0011;
        tick();
        chk("t6_ptr0_grant", 64'(grant), 64'h1);
        tick();
        ledger_ack = 1'b1;
        tick();
        ledger_ack = 1'b0;
        chk("t6_ack0", 64'(ack), 64'h1);
        req = 4'b0000;
        tick();
        chk("t6_rel", 64'(grant), 64'h0);

        // ledger_ack while idle is ignored
        ledger_ack = 1'b1;
        tick();
        ledger_ack = 1'b0;
        chk("idle_ack_ignored", 64'(ack), 64'h0);
        chk("idle_ocupado", 64'(ocupado), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
